// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: request front-end for a single-port synchronous memory.
//   Accepts read/write requests on a valid/ready channel. Each accepted
//   request drives the memory port in the same cycle. Read data, which the
//   memory returns one cycle later, is buffered with its address in a
//   response FIFO. The FIFO drains on a valid/ready response channel.
//   A read is accepted only when a FIFO slot is guaranteed for it, counting
//   the read already in flight, so read data is never dropped.
//
// Optional build macro: MEM_REQ_CTRL_WR_ACK_EN
//   When defined, writes also produce an in-order response with
//   rsp_write=1 and data 0, and they obey the same slot check as reads.
//
// Ports:
//   clk, reset                 clock, async active-high reset
//   req_valid/ready/write      request handshake and direction
//   req_addr/req_wdata         request address and write data
//   rsp_valid/ready/write      response handshake and write-ack flag
//   rsp_addr/rsp_data          responded address and read data
//   mem_addr/wr_en/rd_en/wdata memory command (combinational from request)
//   mem_rdata                  memory read data, valid the cycle after rd_en
module mem_req_ctrl #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr_en,
  output logic                  mem_rd_en,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                  inflight_q, inflight_wr_q;
  logic [ADDR_WIDTH-1:0] inflight_addr_q;

  logic                  fifo_wr_q   [RSP_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr_q [RSP_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_q [RSP_DEPTH];

  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic [CW-1:0]         occ;
  logic                  slot_free, fire, track, track_wr, push, pop;
  logic [DATA_WIDTH-1:0] push_data;

  // The in-flight access is counted so its slot is reserved before the data
  // arrives; the pop term is deliberately absent to keep rsp_ready off the
  // req_ready path.
  assign occ       = count_q + CW'(inflight_q);
  assign slot_free = occ < CW'(RSP_DEPTH);

`ifdef MEM_REQ_CTRL_WR_ACK_EN
  assign req_ready = ~reset & slot_free;
  assign track     = fire;
  assign track_wr  = req_write;
`else
  assign req_ready = ~reset & (req_write | slot_free);
  assign track     = fire & ~req_write;
  assign track_wr  = 1'b0;
`endif

  assign fire      = req_valid & req_ready;
  assign mem_addr  = req_addr;
  assign mem_wdata = req_wdata;
  assign mem_wr_en = fire & req_write;
  assign mem_rd_en = fire & ~req_write;

  assign push      = inflight_q;
  assign push_data = inflight_wr_q ? '0 : mem_rdata;
  assign pop       = rsp_valid_q & rsp_ready;

  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_data  = rsp_data_q;

  // The response port is a registered copy of the FIFO head. When the new
  // head is the entry being pushed this cycle, it is taken from the push
  // path because the array write has not landed yet.
  always_comb begin
    count_d     = count_q + CW'(push) - CW'(pop);
    wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    rsp_valid_d = count_d != '0;
    rsp_write_d = rsp_write_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_data_d  = rsp_data_q;
    if (count_d != '0) begin
      if (push && rd_ptr_d == wr_ptr_q) begin
        rsp_write_d = inflight_wr_q;
        rsp_addr_d  = inflight_addr_q;
        rsp_data_d  = push_data;
      end else begin
        rsp_write_d = fifo_wr_q[rd_ptr_d];
        rsp_addr_d  = fifo_addr_q[rd_ptr_d];
        rsp_data_d  = fifo_data_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q         <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_wr_q   <= 1'b0;
      inflight_addr_q <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_write_q     <= 1'b0;
      rsp_addr_q      <= '0;
      rsp_data_q      <= '0;
      for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
        fifo_wr_q[i]   <= 1'b0;
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      inflight_q  <= track;
      if (track) begin
        inflight_wr_q   <= track_wr;
        inflight_addr_q <= req_addr;
      end
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_data_q  <= rsp_data_d;
      if (push) begin
        fifo_wr_q[wr_ptr_q]   <= inflight_wr_q;
        fifo_addr_q[wr_ptr_q] <= inflight_addr_q;
        fifo_data_q[wr_ptr_q] <= push_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
module tb_mem_req_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_ready, req_write;
  logic [1:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_ready, rsp_write;
  logic [1:0] rsp_addr;
  logic [7:0] rsp_data;
  logic [1:0] mem_addr;
  logic       mem_wr_en, mem_rd_en;
  logic [7:0] mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_req_ctrl #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .RSP_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Single-port memory: registered read data, cleared on reset.
  logic [7:0] mem_q [4];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
      mem_rdata <= '0;
    end else begin
      if (mem_wr_en) mem_q[mem_addr] <= mem_wdata;
      if (mem_rd_en) mem_rdata <= mem_q[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // stim = {valid, write, addr[1:0], wdata[7:0], rsp_ready}
  // exp  = {req_ready, mem_wr_en, mem_rd_en, rsp_valid, rsp_write, rsp_addr[1:0], rsp_data[7:0]}
  typedef struct {
    logic [12:0] stim;
    logic [14:0] exp;
  } vec_t;

  vec_t vecs [12];
  logic [9:0] exp_rsp [6];

  initial begin
    vecs[0]  = '{{1'b0,1'b0,2'd0,8'h00,1'b1}, {1'b1,1'b0,1'b0,1'b0,1'b0,2'd0,8'h00}};
    vecs[1]  = '{{1'b1,1'b1,2'd2,8'hA5,1'b1}, {1'b1,1'b1,1'b0,1'b0,1'b0,2'd0,8'h00}};
    vecs[2]  = '{{1'b1,1'b0,2'd2,8'h00,1'b1}, {1'b1,1'b0,1'b1,1'b0,1'b0,2'd0,8'h00}};
    vecs[3]  = '{{1'b0,1'b0,2'd0,8'h00,1'b1}, {1'b1,1'b0,1'b0,1'b0,1'b0,2'd0,8'h00}};
    vecs[4]  = '{{1'b0,1'b0,2'd0,8'h00,1'b1}, {1'b1,1'b0,1'b0,1'b1,1'b0,2'd2,8'hA5}};
    vecs[5]  = '{{1'b1,1'b0,2'd0,8'h00,1'b1}, {1'b1,1'b0,1'b1,1'b0,1'b0,2'd2,8'hA5}};
    vecs[6]  = '{{1'b1,1'b0,2'd1,8'h00,1'b1}, {1'b1,1'b0,1'b1,1'b0,1'b0,2'd2,8'hA5}};
    vecs[7]  = '{{1'b1,1'b0,2'd2,8'h00,1'b1}, {1'b1,1'b0,1'b1,1'b1,1'b0,2'd0,8'h00}};
    vecs[8]  = '{{1'b1,1'b0,2'd3,8'h00,1'b1}, {1'b1,1'b0,1'b1,1'b1,1'b0,2'd1,8'h00}};
    vecs[9]  = '{{1'b0,1'b0,2'd0,8'h00,1'b1}, {1'b1,1'b0,1'b0,1'b1,1'b0,2'd2,8'hA5}};
    vecs[10] = '{{1'b0,1'b0,2'd0,8'h00,1'b1}, {1'b1,1'b0,1'b0,1'b1,1'b0,2'd3,8'h00}};
    vecs[11] = '{{1'b0,1'b0,2'd0,8'h00,1'b1}, {1'b1,1'b0,1'b0,1'b0,1'b0,2'd3,8'h00}};
    exp_rsp[0] = {2'd0, 8'h00};
    exp_rsp[1] = {2'd1, 8'h00};
    exp_rsp[2] = {2'd2, 8'h00};
    exp_rsp[3] = {2'd3, 8'h00};
    exp_rsp[4] = {2'd0, 8'h11};
    exp_rsp[5] = {2'd1, 8'h00};

    // Reset state, with a read request presented during reset
    reset = 1'b1; rsp_ready = 1'b1;
    idle_inputs();
    req_valid = 1'b1;
    #1;
    check("reset_req_ready", {31'd0, req_ready}, 32'd0);
    check("reset_mem_rd_en", {31'd0, mem_rd_en}, 32'd0);
    check("reset_rsp", {21'd0, rsp_valid, rsp_write, rsp_addr, rsp_data}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;

`ifndef MEM_REQ_CTRL_WR_ACK_EN
    // Vector table: write/read-after-write, back-to-back reads
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      {req_valid, req_write, req_addr, req_wdata, rsp_ready} = vecs[i].stim;
      #1;
      check($sformatf("vec%0d", i),
            {17'd0, req_ready, mem_wr_en, mem_rd_en, rsp_valid, rsp_write, rsp_addr, rsp_data},
            {17'd0, vecs[i].exp});
      @(negedge clk);
    end

    // Backpressure: reads stall at 4 outstanding, writes still pass
    do_reset();
    begin
      int issued = 0;
      int nrsp = 0;
      int cyc = 0;
      rsp_ready = 1'b0;
      for (int c = 0; c < 8; c++) begin
        req_valid = 1'b1; req_write = 1'b0; req_addr = 2'(issued % 4);
        #1;
        if (req_ready) issued++;
        @(negedge clk);
      end
      check("stall_accepted", issued, 4);
      #1;
      check("stall_req_ready", {31'd0, req_ready}, 32'd0);
      req_write = 1'b1; req_addr = 2'd0; req_wdata = 8'h11;
      #1;
      check("stall_write_ready", {30'd0, req_ready, mem_wr_en}, 32'd3);
      @(negedge clk);
      while ((nrsp < 6 || issued < 6) && cyc < 40) begin
        req_write = 1'b0; req_valid = (issued < 6); req_addr = 2'(issued % 4);
        rsp_ready = 1'b1;
        #1;
        if (rsp_valid) begin
          if (nrsp < 6)
            check($sformatf("drain_rsp%0d", nrsp), {22'd0, rsp_addr, rsp_data}, {22'd0, exp_rsp[nrsp]});
          nrsp++;
        end
        if (req_valid && req_ready) issued++;
        @(negedge clk);
        cyc++;
      end
      idle_inputs();
      check("drain_rsp_count", nrsp, 6);
      check("drain_issued", issued, 6);
    end
`endif

    // Reset with 2 responses buffered and 1 read in flight
    do_reset();
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = 2'(i);
      @(negedge clk);
    end
    idle_inputs();
    #1;
    check("pre_reset_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    reset = 1'b1;
    #1;
    check("midreset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("midreset_req_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    rsp_ready = 1'b1;
    #1;
    check("post_reset_req_ready", {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("post_reset_no_rsp%0d", i), {31'd0, rsp_valid}, 32'd0);
    end

`ifdef MEM_REQ_CTRL_WR_ACK_EN
    // Write ack then read response, in request order
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd1; req_wdata = 8'h3C;
    #1;
    check("ack_write_fire", {30'd0, req_ready, mem_wr_en}, 32'd3);
    @(negedge clk);
    req_write = 1'b0; req_wdata = 8'h00;
    #1;
    check("ack_read_fire", {30'd0, req_ready, mem_rd_en}, 32'd3);
    @(negedge clk);
    idle_inputs();
    #1;
    check("ack_rsp0", {20'd0, rsp_valid, rsp_write, rsp_addr, rsp_data}, {20'd0, 1'b1, 1'b1, 2'd1, 8'h00});
    @(negedge clk);
    #1;
    check("ack_rsp1", {20'd0, rsp_valid, rsp_write, rsp_addr, rsp_data}, {20'd0, 1'b1, 1'b0, 2'd1, 8'h3C});
    @(negedge clk);
    #1;
    check("ack_empty", {31'd0, rsp_valid}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_req_ctrl.md
Name: mem_req_ctrl

Overview:
- Request front-end that sits directly upstream of the single-port memory model and drives its addr/wr_en/rd_en/wdata port.
- Accepts read/write requests on a valid/ready channel and issues at most one memory access per cycle.
- Captures the memory's registered read data, one cycle after issue, into a response FIFO.
- Returns read data with the request address on a valid/ready response channel, with credit-based backpressure so no read data is ever lost.

Parameters:
- ADDR_WIDTH, 2, memory address width; must match the memory instance.
- DATA_WIDTH, 8, memory data width; must match the memory instance.
- RSP_DEPTH, 4, response FIFO entries, power of two, >=2. Values >=3 sustain one read per cycle.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when req_valid&req_ready.
- req_write  input  1  1=write, 0=read.
- req_addr  input  ADDR_WIDTH  request address.
- req_wdata  input  DATA_WIDTH  write data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  response consumed when rsp_valid&rsp_ready.
- rsp_write  output  1  1=write ack (macro only), else 0.
- rsp_addr  output  ADDR_WIDTH  address of the responded request.
- rsp_data  output  DATA_WIDTH  read data; 0 for write acks.
- mem_addr  output  ADDR_WIDTH  to memory addr.
- mem_wr_en  output  1  to memory wr_en.
- mem_rd_en  output  1  to memory rd_en.
- mem_wdata  output  DATA_WIDTH  to memory wdata.
- mem_rdata  input  DATA_WIDTH  from memory rdata; valid the cycle after mem_rd_en.

Behaviour:
- Interface: one clock clk; reset is asynchronous, active-high; all flops clear immediately on reset assertion.
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_write=0, rsp_addr=0, rsp_data=0.
  - FIFO count=0, in-flight flag=0, pointers=0.
  - mem_wr_en=0, mem_rd_en=0.
- mem_* outputs are combinational from the request channel:
  - mem_addr=req_addr, mem_wdata=req_wdata.
  - mem_wr_en = fire & req_write.
  - mem_rd_en = fire & ~req_write.
  - The memory samples them on the same edge that accepts the request.
- Occupancy = FIFO count + in-flight flag. The in-flight flag is set the cycle after a read fire and cleared the following cycle.
- req_ready:
  - 0 while reset is asserted.
  - Otherwise, for a read, 1 iff occupancy < RSP_DEPTH.
  - Otherwise, for a write (macro off), 1 unconditionally.
  - It may depend on req_valid/req_write.
  - It must not depend combinationally on rsp_ready. A pop frees a slot only from the next cycle.
- Read latency:
  - Read fires at edge E.
  - Memory updates rdata at E.
  - The controller pushes {addr, mem_rdata} into the FIFO at E+1.
  - rsp_valid=1 from E+1 (registered FIFO head, no bypass).
- Writes: the memory updates at the fire edge. A read to the same address issued the next cycle returns the new data.
- FIFO behaviour:
  - In-order; push and pop in the same cycle allowed; count unchanged.
  - Pointers wrap modulo RSP_DEPTH.
  - Full: reads stall, pending request held stable by upstream.
  - Empty: rsp_valid=0, rsp_* hold the last value.
- While rsp_valid&~rsp_ready, rsp_* are held stable.
- Reset mid-operation: the in-flight read and all buffered responses are discarded; no response is produced for them. The memory clears its own contents on reset.
- The request address is stored with the read so rsp_addr matches rsp_data. Read data is captured only when the in-flight flag is set, never from a stale mem_rdata.

Optional Feature:
- Macro: MEM_REQ_CTRL_WR_ACK_EN.
- Defined:
  - Every accepted write also consumes a response slot.
  - Writes use the same req_ready rule as reads.
  - At E+1 the write pushes {write=1, addr, data=0}.
  - Responses interleave with reads in request order.
- Undefined:
  - Writes produce no response and never stall.
  - rsp_write is tied to 0.

Test Plan:
- Write addr2=0xA5, then read addr2 next cycle, rsp_ready=1 -> rsp_valid two edges after the read fire with rsp_addr=2, rsp_data=0xA5.
- Reset, then read addr0..3 -> data 0x00 each, responses in order 0,1,2,3.
- Back-to-back reads addr0..3 with rsp_ready=1 and RSP_DEPTH=4 -> req_ready stays 1; one response per cycle.
- rsp_ready=0, issue 6 reads (RSP_DEPTH=4) -> exactly 4 accepted, req_ready=0 thereafter, writes still accepted (macro off). Raise rsp_ready -> the 4 responses arrive, then the remaining 2 are accepted.
- Assert reset with 2 responses buffered and 1 in flight -> rsp_valid=0 immediately. After release, no stale response appears, and req_ready=1 on the first cycle after release.
- MEM_REQ_CTRL_WR_ACK_EN defined, write addr1=0x3C then read addr1 -> responses {rsp_write=1, addr1, data=0x00} then {rsp_write=0, addr1, data=0x3C}.
